// File: rtl/fifo_pkg.sv
// Constants and helpers shared by the async FIFO, its synchronisers and its
// read-side consumers.
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 32;
  localparam int FIFO_ADDR_WIDTH = 4;

  // Bits needed to index n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/fifo_rd_unpack.sv
// Read-side FIFO consumer: pops DATA_WIDTH words from a show-ahead FIFO and
// emits them as a valid/ready stream of OUT_WIDTH slices.
module fifo_rd_unpack
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int OUT_WIDTH  = 8,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic                  m_last
);

  localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
  localparam int IDX_W = clog2_min1(RATIO);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RATIO - 1);

  if (DATA_WIDTH % OUT_WIDTH != 0) begin : g_bad_ratio
    $error("fifo_rd_unpack: DATA_WIDTH must be a multiple of OUT_WIDTH");
  end

  logic [DATA_WIDTH-1:0] word_q;
  logic                  word_vld;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      sel;
  logic                  at_last;
  logic                  fire;
  logic                  last_fire;
  logic [OUT_WIDTH-1:0]  slices [RATIO];

  for (genvar i = 0; i < RATIO; i++) begin : g_slice
    assign slices[i] = word_q[i*OUT_WIDTH +: OUT_WIDTH];
  end

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    at_last   = (idx == IDX_LAST);
    fire      = word_vld & m_ready;
    last_fire = fire & at_last;
    sel       = LSB_FIRST ? idx : IDX_LAST - idx;
    // Popping while the holding register drains its last slice keeps words back-to-back.
    rinc      = ~rrst & ~flush & ~rempty & (~word_vld | last_fire);
  end

  assign m_valid = word_vld;
  assign m_data  = slices[sel];
  assign m_last  = word_vld & at_last;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      word_q   <= '0;
      word_vld <= 1'b0;
      idx      <= '0;
    end else if (flush) begin
      word_vld <= 1'b0;
      idx      <= '0;
    end else if (rinc) begin
      word_q   <= rdata;
      word_vld <= 1'b1;
      idx      <= '0;
    end else if (last_fire) begin
      word_vld <= 1'b0;
      idx      <= '0;
    end else if (fire) begin
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: doc/fifo_rd_unpack.md
Name: fifo_rd_unpack

Overview:
Read-side consumer of the async FIFO, in the rclk domain. It pops DATA_WIDTH words through the FIFO read port (rinc/rempty/rdata) and emits them as a narrower valid/ready stream of OUT_WIDTH slices. The FIFO memory read is combinational (show-ahead), so rdata is valid whenever rempty is low. A one-word holding register decouples FIFO pops from downstream back-pressure without losing throughput.

Parameters:
DATA_WIDTH, 32, FIFO word width; must equal the FIFO DATA_WIDTH.
OUT_WIDTH, 8, output slice width; DATA_WIDTH % OUT_WIDTH must be 0.
LSB_FIRST, 1, 1 = slice 0 is rdata[OUT_WIDTH-1:0]; 0 = most significant slice first.
Derived localparams: RATIO = DATA_WIDTH/OUT_WIDTH; IDX_W = max(1, clog2(RATIO)).

Ports:
rclk  in  1  read-domain clock
rrst  in  1  asynchronous reset, active-high
rempty  in  1  FIFO empty flag
rdata  in  DATA_WIDTH  FIFO head word, combinational from FIFO memory
rinc  out  1  FIFO pop request, combinational
flush  in  1  synchronous discard of the held word
m_valid  out  1  output slice valid
m_ready  in  1  downstream accept
m_data  out  OUT_WIDTH  output slice
m_last  out  1  high on the final slice of a word

Behaviour:
- Reset (rrst high, async): word_q=0, word_vld=0, idx=0. Outputs: m_valid=0, m_data=0, m_last=0 (with RATIO>1), rinc=0. Release is synchronous to rclk in the integrating design.
- Definitions: fire = m_valid & m_ready; last_fire = fire & (idx==RATIO-1).
- Pop: rinc = ~rst & ~flush & ~rempty & (~word_vld | last_fire).
- On a rclk edge with rinc=1: word_q<=rdata, word_vld<=1, idx<=0.
- On last_fire without rinc: word_vld<=0, idx<=0.
- On fire that is not last: idx<=idx+1.
- m_valid = word_vld. m_data = slice idx of word_q, ordered per LSB_FIRST. m_last = word_vld & (idx==RATIO-1).
- Latency: first m_valid is asserted on the rclk edge after the first cycle with rempty=0. No cycle boundary is lost between words: the pop on last_fire refills word_q in the same edge.
- Throughput: one slice per cycle while m_ready=1 and the FIFO is non-empty.
- Stability: while m_valid=1 and m_ready=0, m_data and m_last hold. Only flush or reset may drop m_valid without a handshake.
- Flush (priority over everything except reset): word_vld<=0, idx<=0, rinc forced 0 in that cycle, any fire in that cycle is ignored. The FIFO pointer is untouched.
- Empty: with rempty=1, rinc is never asserted. After last_fire, m_valid drops the next cycle.
- RATIO=1: degenerates to a registered pass-through stage. m_last=m_valid. idx is constant 0.
- Wrap: idx only counts 0..RATIO-1. It never increments past RATIO-1.
- Reset mid-word: the partial word is discarded, with no pop.
- The block never asserts rinc while rempty=1. The FIFO relies on this, because its memory is not guarded on the read side.

Decomposition:
- The shared package fifo_pkg holds the default DATA_WIDTH and ADDR_WIDTH constants plus a clog2-max-1 helper function. It is shared with the FIFO and sync blocks.
- No sub-module. The slice mux is a single indexed part-select, and the control logic is about 40 lines.
- A parameter check (DATA_WIDTH % OUT_WIDTH != 0) triggers an elaboration error.

Test Plan:
- Single word, m_ready=1: rdata=32'hA1B2C3D4, rempty low for one cycle. Required response: rinc pulses once; m_data = D4, C3, B2, A1 on 4 consecutive cycles; m_last only on A1; then m_valid=0.
- Back-to-back: the FIFO holds 32'h03020100 and 32'h07060504, m_ready=1. Required response: slices 00..07 appear on 8 contiguous cycles with no bubble; rinc fires on cycle 0 and on the cycle slice 03 is accepted.
- Back-pressure: m_ready=0 for 5 cycles after slice B2. Required response: m_data stays B2, m_valid stays 1, rinc stays 0; resuming m_ready yields B2, then A1.
- LSB_FIRST=0 with word 32'hA1B2C3D4. Required response: order A1, B2, C3, D4.
- Flush during slice index 2 of word W0, with W1 queued. Required response: next cycle m_valid=0 and rinc=0 during the flush cycle; the following cycle pops W1, and its slice 0 is output.
- Async rrst asserted mid-word with no clock edge. Required response: m_valid, m_data, m_last and rinc go to 0 immediately; no pop occurs until reset is released and rempty=0.
